// File: rtl/alu_4bit_pkg.sv
// Shared constants and operation encoding for the registered 4-bit add/subtract unit.
package alu_4bit_pkg;

    localparam int WIDTH = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/alu_4bit_adder.sv
// Combinational ripple-carry adder; also exposes the carry into the MSB for overflow detection.
module alu_4bit_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         msb_cin
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout    = carry[W];
    assign msb_cin = carry[W-1];

endmodule

// File: rtl/alu_4bit.sv
// Registered add/subtract with carry-out; zero/negative/overflow flags exist only when ALU_4BIT_FLAGS_EN is defined.
module alu_4bit
    import alu_4bit_pkg::*;
#(
    parameter int WIDTH = alu_4bit_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_select,
`ifdef ALU_4BIT_FLAGS_EN
    output logic             zero,
    output logic             negative,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             out_valid
);

    op_t              op;
    logic             is_sub;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             msb_cin;

    // Subtract reuses the adder as a + ~b + 1, so cout is already NOT borrow.
    assign op     = op_t'(op_select);
    assign is_sub = (op == OP_SUB);
    assign y_in   = is_sub ? ~b : b;

    alu_4bit_adder #(.W(WIDTH)) u_adder (
        .x       (a),
        .y       (y_in),
        .cin     (is_sub),
        .sum     (sum),
        .cout    (cout),
        .msb_cin (msb_cin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= sum;
                carry_out <= cout;
            end
        end
    end

`ifdef ALU_4BIT_FLAGS_EN
    // Carry into and out of the MSB disagree exactly when the signed result overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero     <= 1'b1;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (in_valid) begin
            zero     <= (sum == '0);
            negative <= sum[WIDTH-1];
            overflow <= msb_cin ^ cout;
        end
    end
`else
    logic unused_msb_cin;
    assign unused_msb_cin = msb_cin;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: driver pushes model results, a negedge monitor pops and compares.
module tb_alu_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       op_select;
    logic [3:0] result;
    logic       carry_out;
    logic       out_valid;
`ifdef ALU_4BIT_FLAGS_EN
    logic       zero;
    logic       negative;
    logic       overflow;
`endif

    alu_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op_select (op_select),
`ifdef ALU_4BIT_FLAGS_EN
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
`endif
        .result    (result),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t model(input int ua, input int ub, input bit sub);
        exp_t e;
        int   raw;
        int   sa;
        int   sb;
        int   s;
        raw  = sub ? (ua - ub) : (ua + ub);
        e.r  = 4'((raw % 16 + 16) % 16);
        e.c  = sub ? (ua >= ub) : (raw > 15);
        sa   = (ua > 7) ? ua - 16 : ua;
        sb   = (ub > 7) ? ub - 16 : ub;
        s    = sub ? (sa - sb) : (sa + sb);
        e.v  = (s > 7) || (s < -8);
        e.z  = (e.r == 4'd0);
        e.n  = (e.r >= 4'd8);
        return e;
    endfunction

    function automatic exp_t reset_vals();
        exp_t e;
        e.r = 4'd0; e.c = 1'b0; e.z = 1'b1; e.n = 1'b0; e.v = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_result"}, int'(result), int'(e.r));
        check({tag, "_carry"}, int'(carry_out), int'(e.c));
`ifdef ALU_4BIT_FLAGS_EN
        check({tag, "_zero"}, int'(zero), int'(e.z));
        check({tag, "_negative"}, int'(negative), int'(e.n));
        check({tag, "_overflow"}, int'(overflow), int'(e.v));
`endif
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation;
    // idle cycles must hold the last delivered values.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_valid: got out_valid 1 expected 0 at %0t", $time);
                    end else begin
                        last = q.pop_front();
                        check_outputs("valid", last);
                    end
                end else begin
                    check("out_valid_known", int'(out_valid), 0);
                    check_outputs("hold", last);
                end
            end
        end
    end

    task automatic issue(input int ua, input int ub, input bit sub);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        a         = 4'(ua);
        b         = 4'(ub);
        op_select = sub;
        q.push_back(model(ua, ub, sub));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, "_rst_valid"}, int'(out_valid), 0);
        check_outputs({tag, "_rst"}, reset_vals());
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        op_select = 1'b0;
        last      = reset_vals();
        #1;
        check_reset_now("power_on");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases and boundaries
        issue(3, 5, 0);
        issue(9, 8, 0);
        issue(7, 3, 1);
        issue(3, 7, 1);
        issue(15, 15, 0);
        issue(0, 0, 1);
        issue(0, 1, 1);
        issue(8, 1, 1);
        issue(5, 5, 1);
        idle(4);

        // Reset with an operation still in flight
        issue(15, 15, 0);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        last = reset_vals();
        #1;
        check_reset_now("mid_stream");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);

        // Valid on the very first edge after release
        #2;
        rst_n = 1'b0;
        last  = reset_vals();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        a         = 4'd6;
        b         = 4'd11;
        op_select = 1'b1;
        q.push_back(model(6, 11, 1));
        idle(2);

        // Randomized traffic with random idle gaps
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle(int'($urandom_range(1, 3)));
            else
                issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        idle(4);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d outstanding expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
